// File: rtl/systolic_matmul_ctrl.sv
// rtl/systolic_matmul_ctrl.sv - serial-feed / drain / row-major readout controller for an H x W MAC array
module systolic_matmul_ctrl #(
  parameter int width_p        = 32,
  parameter int array_width_p  = 2,
  parameter int array_height_p = 2,
  parameter int max_k_p        = 16,
  parameter int drain_p        = 4
) (
  input  logic                                                 clk_i,
  input  logic                                                 reset_ni,
  input  logic [$clog2(max_k_p+1)-1:0]                         k_i,
  input  logic                                                 flush_i,
  input  logic                                                 valid_i,
  output logic                                                 ready_o,
  input  logic [width_p-1:0]                                   data_i,
  output logic                                                 valid_o,
  input  logic                                                 yumi_i,
  output logic [width_p-1:0]                                   data_o,
  output logic                                                 busy_o,
  output logic [width_p*(array_height_p+array_width_p)-1:0]    lane_data_o,
  output logic [array_height_p+array_width_p-1:0]              lane_valid_o,
  input  logic [array_height_p+array_width_p-1:0]              lane_ready_i,
  input  logic [width_p*array_height_p*array_width_p-1:0]      z_i,
  output logic                                                 clear_o
);

  localparam int L  = array_height_p + array_width_p;
  localparam int N  = array_height_p * array_width_p;
  localparam int LW = (L > 1) ? $clog2(L) : 1;
  localparam int OW = (N > 1) ? $clog2(N) : 1;
  localparam int KW = $clog2(max_k_p + 1);
  localparam int DW = ($clog2(drain_p + 1) > 1) ? $clog2(drain_p + 1) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN, S_OUT, S_CLEAR} state_t;

  state_t          r_state,    w_state_nx;
  logic [LW-1:0]   r_lane_idx, w_lane_idx_nx;
  logic [KW-1:0]   r_step,     w_step_nx;
  logic [OW-1:0]   r_out_idx,  w_out_idx_nx;
  logic [DW-1:0]   r_drain,    w_drain_nx;
  logic [KW-1:0]   r_k,        w_k_nx;

  logic            w_ready;
  logic            w_xfer;
  logic [KW-1:0]   w_k_eff;
  logic [KW-1:0]   w_k_cur;
  logic            w_lane_last;
  logic            w_step_last;
  logic [LW-1:0]   w_lane_adv;
  logic [KW-1:0]   w_step_adv;
  logic [width_p-1:0] w_z_word;

  always_comb begin
    w_k_eff = k_i;
    if (k_i == '0) begin
      w_k_eff = KW'(1);
    end else if (k_i > KW'(max_k_p)) begin
      w_k_eff = KW'(max_k_p);
    end
  end

  // In IDLE the job's K is not yet registered, so the end-of-feed test uses the live clamp.
  assign w_k_cur     = (r_state == S_IDLE) ? w_k_eff : r_k;
  assign w_ready     = ((r_state == S_IDLE) || (r_state == S_LOAD)) && lane_ready_i[r_lane_idx];
  assign w_xfer      = valid_i & w_ready;
  assign w_lane_last = (r_lane_idx == LW'(L - 1));
  assign w_step_last = (r_step == (w_k_cur - KW'(1)));
  assign w_lane_adv  = w_lane_last ? '0 : r_lane_idx + LW'(1);
  assign w_step_adv  = w_lane_last ? r_step + KW'(1) : r_step;

  always_comb begin
    w_state_nx    = r_state;
    w_lane_idx_nx = r_lane_idx;
    w_step_nx     = r_step;
    w_out_idx_nx  = r_out_idx;
    w_drain_nx    = r_drain;
    w_k_nx        = r_k;
    case (r_state)
      S_IDLE, S_LOAD: begin
        if (flush_i) begin
          w_state_nx = S_CLEAR;
        end else if (w_xfer) begin
          if (r_state == S_IDLE) begin
            w_k_nx = w_k_eff;
          end
          w_lane_idx_nx = w_lane_adv;
          w_step_nx     = w_step_adv;
          if (w_lane_last && w_step_last) begin
            w_state_nx = S_DRAIN;
            w_drain_nx = '0;
          end else begin
            w_state_nx = S_LOAD;
          end
        end
      end
      S_DRAIN: begin
        if (flush_i) begin
          w_state_nx = S_CLEAR;
        end else if (r_drain == DW'(drain_p - 1)) begin
          if (&lane_ready_i) begin
            w_state_nx   = S_OUT;
            w_out_idx_nx = '0;
          end
        end else begin
          w_drain_nx = r_drain + DW'(1);
        end
      end
      S_OUT: begin
        if (flush_i) begin
          w_state_nx = S_CLEAR;
        end else if (yumi_i) begin
          if (r_out_idx == OW'(N - 1)) begin
            w_state_nx = S_CLEAR;
          end else begin
            w_out_idx_nx = r_out_idx + OW'(1);
          end
        end
      end
      S_CLEAR: begin
        w_state_nx    = S_IDLE;
        w_lane_idx_nx = '0;
        w_step_nx     = '0;
        w_out_idx_nx  = '0;
        w_drain_nx    = '0;
        w_k_nx        = '0;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state    <= S_IDLE;
      r_lane_idx <= '0;
      r_step     <= '0;
      r_out_idx  <= '0;
      r_drain    <= '0;
      r_k        <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_lane_idx <= w_lane_idx_nx;
      r_step     <= w_step_nx;
      r_out_idx  <= w_out_idx_nx;
      r_drain    <= w_drain_nx;
      r_k        <= w_k_nx;
    end
  end

  // Row-major result select, written as a loop so any H x W works without a hand mux.
  always_comb begin
    w_z_word = '0;
    for (int i = 0; i < N; i++) begin
      if (r_out_idx == OW'(i)) begin
        w_z_word = z_i[i*width_p +: width_p];
      end
    end
  end

  always_comb begin
    lane_valid_o = '0;
    if (w_xfer) begin
      lane_valid_o[r_lane_idx] = 1'b1;
    end
  end

  assign lane_data_o = {L{data_i}};
  assign ready_o     = w_ready;
  assign valid_o     = (r_state == S_OUT);
  assign data_o      = (r_state == S_OUT) ? w_z_word : '0;
  assign clear_o     = (r_state == S_CLEAR);
  assign busy_o      = (r_state != S_IDLE);

endmodule

// File: doc/systolic_matmul_ctrl.md
Name: systolic_matmul_ctrl

Overview:
Parametrised controller that streams a serial operand feed into an H x W MAC array over K inner-product steps. It waits for a configurable drain interval, then reads out all H*W results in row-major order over a valid/yumi producer handshake. It then clears the array for the next job. The controller drives array-facing lane ports directly, so it works with any array geometry and has no hardcoded output mux.

Parameters:
width_p, 32, operand/result width in bits
array_width_p, 2, columns W (>=1)
array_height_p, 2, rows H (>=1)
max_k_p, 16, maximum inner dimension K accepted on k_i
drain_p, 4, cycles waited after last operand before readout (>=1)

Ports:
clk_i  in  1  clock
reset_ni  in  1  asynchronous active-low reset
k_i  in  $clog2(max_k_p+1)  inner dimension; sampled on the first accepted word of a job
flush_i  in  1  abort/clear request
valid_i  in  1  consumer: data_i valid
ready_o  out  1  consumer: controller can accept data_i
data_i  in  width_p  serial operand word
valid_o  out  1  producer: data_o valid
yumi_i  in  1  producer: downstream consumes data_o
data_o  out  width_p  result word
busy_o  out  1  state != IDLE
lane_data_o  out  width_p*(H+W)  data_i replicated to every lane
lane_valid_o  out  H+W  one-hot lane strobe; bits 0..H-1 = rows, H..H+W-1 = columns
lane_ready_i  in  H+W  per-lane ready from the array
z_i  in  width_p*H*W  array results; element (r,c) at slice index r*W+c, LSB first
clear_o  out  1  one-cycle array accumulator clear

Behaviour:
- Reset is asynchronous active-low. Values while reset is asserted:
  - state = IDLE; lane_idx, step, out_idx and drain counters = 0; k_r = 0.
  - valid_o = 0, clear_o = 0, busy_o = 0, lane_valid_o = 0.
- States: IDLE, LOAD, DRAIN, OUT, CLEAR.
- Transfer condition: valid_i & ready_o.
- ready_o = lane_ready_i[lane_idx] in IDLE (lane_idx = 0) and in LOAD; ready_o = 0 in all other states.
- lane_valid_o[lane_idx] = transfer (combinational); all other lane strobes are 0.
- IDLE:
  - flush_i -> CLEAR. flush_i has priority over valid_i.
  - On transfer: k_r = (k_i == 0 ? 1 : min(k_i, max_k_p)); word goes to lane 0; lane_idx = 1; step = 0; go to LOAD.
  - Special case H+W = 1 with k_r = 1: go directly to DRAIN.
- LOAD:
  - Each transfer increments lane_idx. When lane_idx = H+W-1 it wraps to 0 and step increments.
  - A transfer at lane_idx = H+W-1 with step = k_r-1 -> DRAIN, drain counter = 0.
  - No transfer -> counters hold. A stalled lane_ready_i only stalls ready_o; no data is dropped.
- DRAIN:
  - Drain counter increments each cycle.
  - Exit to OUT when counter = drain_p-1 and &lane_ready_i. If the array is not ready, stay in DRAIN with the counter saturated. out_idx = 0 on exit.
- OUT:
  - valid_o = 1; data_o = z_i[out_idx*width_p +: width_p].
  - data_o and valid_o stay stable until yumi_i.
  - On yumi_i, out_idx increments. yumi_i at out_idx = H*W-1 -> CLEAR.
- CLEAR: clear_o = 1 for exactly one cycle, then IDLE. All counters return to 0.
- flush_i in LOAD, DRAIN or OUT:
  - Abort to CLEAR on the next edge. Partial results are discarded.
  - A transfer or yumi in the same cycle is still honoured at the port, but no further words are produced.
- yumi_i while valid_o = 0 is ignored.
- data_o is 0 outside OUT.
- Counter widths:
  - lane_idx: max(1, $clog2(H+W)).
  - out_idx: max(1, $clog2(H*W)).
  - step: $clog2(max_k_p+1).
  - drain counter: max(1, $clog2(drain_p+1)).
- Total accepted words per job = k_r*(H+W).
- Minimum job latency, first word to first valid_o = k_r*(H+W) + drain_p cycles with no stalls.
- No combinational path from yumi_i to valid_o. The only combinational path from valid_i is to lane_valid_o.

Test Plan:
- 2x2, k_i=1, drain_p=4, all lanes ready; feed 1,2,3,4 with z_i = {40,30,20,10} -> lane_valid_o strobes 0001, 0010, 0100, 1000. After 4 drain cycles, data_o = 10,20,30,40 with yumi_i held high. Then one clear_o pulse and busy_o falls.
- 3x2 (W=3,H=2), k_i=3, lane_ready_i[2] low for 5 cycles mid-stream -> ready_o low only while lane_idx = 2. Exactly 15 words are accepted, then DRAIN.
- OUT with yumi_i pulsed every third cycle -> data_o/valid_o stable between yumis. Six words are emitted in order r*W+c.
- flush_i asserted in LOAD after 3 words -> next cycle CLEAR with clear_o = 1, then IDLE. The next job restarts at lane 0, step 0.
- k_i=0 in IDLE -> treated as K=1 (H+W words). k_i > max_k_p -> clamped to max_k_p.
- reset_ni asserted asynchronously mid-OUT -> valid_o, clear_o and busy_o drop immediately. After release, a fresh 2x2 job completes correctly.
